pipe_front_regs: RTL

PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

---
 rtl/pipe_front_regs.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: fetch PC, IF/ID and ID/EX pipeline registers for a
// five-stage pipeline. Hazard controls are taken as given and applied
// with a fixed priority. Two saturating counters track stall and flush
// events.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_StallF,
  input  logic             i_StallD,
  input  logic             i_FlushE,
  input  logic             i_PCSrcD,
  input  logic [31:0]      i_PCBranchD,
  input  logic [31:0]      i_InstrF,
  input  logic [7:0]       i_CtrlD,
  input  logic [31:0]      i_RD1D,
  input  logic [31:0]      i_RD2D,
  input  logic [31:0]      i_SignImmD,
  input  logic [4:0]       i_RsD,
  input  logic [4:0]       i_RtD,
  input  logic [4:0]       i_RdD,
  output logic [31:0]      o_PCF,
  output logic [31:0]      o_InstrD,
  output logic [31:0]      o_PCPlus4D,
  output logic             o_ValidD,
  output logic [7:0]       o_CtrlE,
  output logic [31:0]      o_RD1E,
  output logic [31:0]      o_RD2E,
  output logic [31:0]      o_SignImmE,
  output logic [4:0]       o_RsE,
  output logic [4:0]       o_RtE,
  output logic [4:0]       o_RdE,
  output logic             o_ValidE,
  output logic [CNT_W-1:0] o_StallCount,
  output logic [CNT_W-1:0] o_FlushCount
);

  logic [31:0]      r_pcF;
  logic [31:0]      r_instrD;
  logic [31:0]      r_pcPlus4D;
  logic             r_validD;
  logic [7:0]       r_ctrlE;
  logic [31:0]      r_rd1E;
  logic [31:0]      r_rd2E;
  logic [31:0]      r_signImmE;
  logic [4:0]       r_rsE;
  logic [4:0]       r_rtE;
  logic [4:0]       r_rdE;
  logic             r_validE;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  logic [31:0]      w_pcPlus4;
  logic             w_stallEvent;
  logic             w_flushEvent;

  // Sequential PC increment wraps naturally in 32 bits; a branch while
  // Decode is stalled is not a real flush because the branch outcome is
  // not yet trustworthy.
  assign w_pcPlus4    = r_pcF + 32'd4;
  assign w_stallEvent = i_StallF | i_StallD;
  assign w_flushEvent = i_FlushE | (i_PCSrcD & ~i_StallD);

  // Fetch PC: stall holds, then a taken branch redirects, else advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcF <= RESET_PC;
    end else if (i_StallF) begin
      r_pcF <= r_pcF;
    end else if (i_PCSrcD) begin
      r_pcF <= i_PCBranchD;
    end else begin
      r_pcF <= w_pcPlus4;
    end
  end

  // IF/ID: stall holds everything, a taken branch squashes to a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrD   <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else if (i_StallD) begin
      r_instrD   <= r_instrD;
      r_pcPlus4D <= r_pcPlus4D;
      r_validD   <= r_validD;
    end else if (i_PCSrcD) begin
      r_instrD   <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else begin
      r_instrD   <= i_InstrF;
      r_pcPlus4D <= w_pcPlus4;
      r_validD   <= 1'b1;
    end
  end

  // ID/EX: never holds; FlushE is the only way to inject a bubble.
  always_ff @(posedge clk) begin
    if (reset || i_FlushE) begin
      r_ctrlE    <= '0;
      r_rd1E     <= '0;
      r_rd2E     <= '0;
      r_signImmE <= '0;
      r_rsE      <= '0;
      r_rtE      <= '0;
      r_rdE      <= '0;
      r_validE   <= 1'b0;
    end else begin
      r_ctrlE    <= i_CtrlD;
      r_rd1E     <= i_RD1D;
      r_rd2E     <= i_RD2D;
      r_signImmE <= i_SignImmD;
      r_rsE      <= i_RsD;
      r_rtE      <= i_RtD;
      r_rdE      <= i_RdD;
      r_validE   <= r_validD;
    end
  end

  // Event counters count at most once per cycle and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_stallEvent && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
      if (w_flushEvent && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + 1'b1;
      end
    end
  end

  assign o_PCF        = r_pcF;
  assign o_InstrD     = r_instrD;
  assign o_PCPlus4D   = r_pcPlus4D;
  assign o_ValidD     = r_validD;
  assign o_CtrlE      = r_ctrlE;
  assign o_RD1E       = r_rd1E;
  assign o_RD2E       = r_rd2E;
  assign o_SignImmE   = r_signImmE;
  assign o_RsE        = r_rsE;
  assign o_RtE        = r_rtE;
  assign o_RdE        = r_rdE;
  assign o_ValidE     = r_validE;
  assign o_StallCount = r_stallCount;
  assign o_FlushCount = r_flushCount;

endmodule
